// File: rtl/dtcm_ctrl_if.sv
// LSU-to-DTCM command/response channel: valid/ready command in, valid/ready response out.
interface dtcm_ctrl_if #(
   parameter int DTCM_ADDR_WIDTH = 16,
   parameter int XLEN            = 32
);
   logic                       dtcm_cmd_valid;
   logic                       dtcm_cmd_ready;
   logic                       dtcm_cmd_read;
   logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr;
   logic [XLEN-1:0]            dtcm_cmd_wdata;
   logic [XLEN/8-1:0]          dtcm_cmd_wmask;
   logic                       dtcm_rsp_valid;
   logic                       dtcm_rsp_ready;
   logic [XLEN-1:0]            dtcm_rsp_rdata;
   logic                       dtcm_rsp_err;

   modport master (
      output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
             dtcm_rsp_ready,
      input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
   );

   modport slave (
      input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask,
             dtcm_rsp_ready,
      output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err
   );
endinterface

// File: rtl/dtcm_ctrl.sv
// DTCM responder: accepts LSU commands, drives a 1-cycle-latency SRAM, returns in-order responses.
// Optional macro DTCM_ADDR_CHK_EN: out-of-range word index is answered with err and no SRAM access.
module dtcm_ctrl #(
   parameter int DTCM_ADDR_WIDTH = 16,
   parameter int XLEN            = 32,
   parameter int DTCM_RAM_AW     = DTCM_ADDR_WIDTH - 2,
   parameter int DTCM_SIZE_WORDS = 2 ** DTCM_RAM_AW
) (
   input  logic                   clk,
   input  logic                   rst,
   dtcm_ctrl_if.slave             lsu,
   output logic                   ram_cs,
   output logic                   ram_we,
   output logic [DTCM_RAM_AW-1:0] ram_addr,
   output logic [XLEN/8-1:0]      ram_wem,
   output logic [XLEN-1:0]        ram_din,
   input  logic [XLEN-1:0]        ram_dout
);
   logic [1:0]      cnt;
   logic            cmd_hs;
   logic            rsp_hs;
   logic            cmd_oob;
   logic            s1_valid;
   logic            s1_read;
   logic            s1_err;
   logic [XLEN-1:0] s1_data;
   logic [XLEN-1:0] fifo_data [2];
   logic [1:0]      fifo_err;
   logic            fifo_rd;
   logic            fifo_wr;
   logic [1:0]      fifo_cnt;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   logic            unused_addr;

   assign lsu.dtcm_cmd_ready = (cnt < 2'd2);
   assign cmd_hs = lsu.dtcm_cmd_valid && lsu.dtcm_cmd_ready;
   assign rsp_hs = lsu.dtcm_rsp_valid && lsu.dtcm_rsp_ready;
   assign unused_addr = ^lsu.dtcm_cmd_addr;

`ifdef DTCM_ADDR_CHK_EN
   localparam logic [DTCM_ADDR_WIDTH-2:0] SIZE_LIM = (DTCM_ADDR_WIDTH-1)'(DTCM_SIZE_WORDS);
   assign cmd_oob = ({1'b0, lsu.dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2]} >= SIZE_LIM);
`else
   logic unused_size;
   assign cmd_oob     = 1'b0;
   assign unused_size = (DTCM_SIZE_WORDS != 0);
`endif

   assign ram_cs   = cmd_hs && !cmd_oob;
   assign ram_we   = ram_cs && !lsu.dtcm_cmd_read;
   assign ram_wem  = lsu.dtcm_cmd_read ? '0 : lsu.dtcm_cmd_wmask;
   assign ram_din  = lsu.dtcm_cmd_wdata;
   assign ram_addr = lsu.dtcm_cmd_addr[DTCM_RAM_AW+1:2];

   // Stage-1 result bypasses the FIFO only when nothing older is waiting.
   assign s1_data    = (s1_read && !s1_err) ? ram_dout : '0;
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign push       = s1_valid && (!fifo_empty || !lsu.dtcm_rsp_ready);
   assign pop        = rsp_hs && !fifo_empty;

   assign lsu.dtcm_rsp_valid = !fifo_empty || s1_valid;
   assign lsu.dtcm_rsp_rdata = fifo_empty ? (s1_valid ? s1_data : '0) : fifo_data[fifo_rd];
   assign lsu.dtcm_rsp_err   = fifo_empty ? (s1_valid && s1_err) : fifo_err[fifo_rd];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= 2'd0;
         s1_valid <= 1'b0;
         s1_read  <= 1'b0;
         s1_err   <= 1'b0;
         fifo_rd  <= 1'b0;
         fifo_wr  <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         s1_valid <= cmd_hs;
         s1_read  <= lsu.dtcm_cmd_read;
         s1_err   <= cmd_oob;
         if (cmd_hs && !rsp_hs)
            cnt <= cnt + 2'd1;
         else if (!cmd_hs && rsp_hs)
            cnt <= cnt - 2'd1;
         if (push)
            fifo_wr <= ~fifo_wr;
         if (pop)
            fifo_rd <= ~fifo_rd;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_err     <= 2'b00;
      end else if (push) begin
         fifo_data[fifo_wr] <= s1_data;
         fifo_err[fifo_wr]  <= s1_err;
      end
   end
endmodule

// File: doc/dtcm_ctrl.md
Name: dtcm_ctrl

Overview:
- Responder end of the LSU-to-DTCM command/response interface. Accepts LSU commands (valid/ready), drives a single-port synchronous DTCM SRAM with 1-cycle read latency, and returns in-order responses (valid/ready).
- A 2-entry response FIFO and credit counter let the LSU keep issuing while the response channel is back-pressured, without losing data.
- Sits beside the core, between the core's lsu2dtcm port and the DTCM RAM macro.

Parameters:
- DTCM_ADDR_WIDTH, 16, byte address width of cmd_addr.
- XLEN, 32, data width.
- DTCM_RAM_AW, DTCM_ADDR_WIDTH-2, SRAM word-address width.
- DTCM_SIZE_WORDS, 2**DTCM_RAM_AW, implemented words; used only with DTCM_ADDR_CHK_EN.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- dtcm_cmd_valid  input  1  LSU command valid
- dtcm_cmd_ready  output  1  controller can accept a command
- dtcm_cmd_read  input  1  1=read, 0=write
- dtcm_cmd_addr  input  DTCM_ADDR_WIDTH  byte address; bits [1:0] ignored
- dtcm_cmd_wdata  input  XLEN  write data
- dtcm_cmd_wmask  input  XLEN/8  byte write enables
- dtcm_rsp_valid  output  1  response valid
- dtcm_rsp_ready  input  1  LSU accepts response
- dtcm_rsp_rdata  output  XLEN  read data; 0 for write responses
- dtcm_rsp_err  output  1  error response; constant 0 unless DTCM_ADDR_CHK_EN
- ram_cs  output  1  SRAM chip select
- ram_we  output  1  SRAM write enable
- ram_addr  output  DTCM_RAM_AW  word address = cmd_addr[DTCM_RAM_AW+1:2]
- ram_wem  output  XLEN/8  byte write mask
- ram_din  output  XLEN  SRAM write data
- ram_dout  input  XLEN  SRAM read data, valid the cycle after a read with cs=1

Behaviour:
- Reset values: cmd_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0. FIFO empty; credit count 0; stage-1 valid 0. ram_* outputs are combinational from cmd and qualified by the handshake.
- Handshake: the command is accepted in cycle T when cmd_valid && cmd_ready.
  - ram_cs = cmd handshake.
  - ram_we = cs && !cmd_read.
  - ram_wem = cmd_read ? 0 : cmd_wmask.
  - ram_din = cmd_wdata.
  - ram_addr and ram_din are driven directly from the cmd_* inputs.
- Stage 1 register captures valid, is_read (and err) at the end of T. ram_dout is valid in T+1.
- Credit counter cnt (0..2) = commands accepted but whose response has not yet been handshaken.
  - cmd_ready = (cnt < 2). It does not look ahead at a same-cycle rsp handshake.
  - Cmd and rsp handshake in the same cycle: cnt unchanged.
- Response path (strict in-order):
  - FIFO empty and stage 1 valid: stage result is presented combinationally in T+1 (rsp_valid=1, rdata = is_read ? ram_dout : 0).
  - If rsp_ready=0 in that cycle, the result is pushed into the FIFO.
  - FIFO non-empty: rsp_* shows the FIFO head; any stage-1 result is pushed to the tail.
  - FIFO pop on rsp handshake.
  - Push and pop in the same cycle are both performed.
- Overflow is impossible because cnt ≤ 2 bounds FIFO occupancy plus stage 1 to 2.
- Minimum latency is 1 cycle (cmd at T, rsp at T+1). Back-to-back throughput is 1 per cycle when rsp_ready is held high.
- rsp_valid, once asserted, stays high with stable rdata/err until handshaken.
- Write responses return rdata=0. The write is committed to SRAM at the T edge, so a read issued at T+1 to the same address returns the new data.
- Reset mid-operation: in-flight and buffered responses are discarded and cnt is cleared. The SRAM write already issued is not undone.

Optional Feature:
- Macro: DTCM_ADDR_CHK_EN.
- Defined:
  - A command whose word index cmd_addr[DTCM_ADDR_WIDTH-1:2] ≥ DTCM_SIZE_WORDS is still accepted normally (consumes a credit), but ram_cs is forced to 0.
  - Its response returns in order with rsp_err=1 and rdata=0, with the same latency as a normal response.
  - An err bit is carried through stage 1 and the FIFO.
- Undefined: no range check; all addresses wrap modulo SRAM size, and rsp_err is tied to 0.

Test Plan:
- Write addr 0x0010, wdata 0xDEADBEEF, wmask 0xF, then read 0x0010 with rsp_ready=1 -> ram_wem=0xF at cycle T; read rsp_valid at T'+1, rdata 0xDEADBEEF, err 0.
- Byte write 0x0010 wdata 0x000000AA, wmask 0x1 over 0xDEADBEEF, then read -> rdata 0xDEADBEAA.
- rsp_ready=0, issue 3 back-to-back reads to 0x0,0x4,0x8 (preloaded 1,2,3) -> cmd_ready drops after 2 accepts. Raise rsp_ready: responses 1,2 in order, third accepted, then rsp 3. cnt never exceeds 2.
- Streaming 8 reads with rsp_ready=1 -> 1 response per cycle, cmd_ready continuously 1, data in order.
- Assert rst while 2 responses are buffered -> rsp_valid=0 and cmd_ready=1 the same cycle (async), no stale responses after release.
- DTCM_ADDR_CHK_EN, DTCM_SIZE_WORDS=1024: read byte addr 0x1000 -> ram_cs=0, rsp at T+1 with err=1, rdata 0. Next read 0x0FFC -> err=0.
